// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the memory-access stage.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package mem_access_unit_pkg;

  localparam int REG_BUS    = 64;
  localparam int MEM_OP_BUS = 4;

  // ex_mem_op: [3] store, [2] unsigned load, [1:0] access size
  localparam logic [MEM_OP_BUS-1:0] MEM_NONE = 4'hF;
  localparam logic [1:0] MEM_B = 2'd0;
  localparam logic [1:0] MEM_H = 2'd1;
  localparam logic [1:0] MEM_W = 2'd2;
  localparam logic [1:0] MEM_D = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Memory op captured from EX and held for the whole bus transaction
  typedef struct packed {
    logic [MEM_OP_BUS-1:0] op;
    logic [REG_BUS-1:0]    addr;
    logic [REG_BUS-1:0]    data;
    logic [4:0]            rd;
  } mem_req_t;

  // Address not a multiple of the access size
  function automatic logic is_misaligned(input logic [2:0] off, input logic [1:0] size);
    logic [2:0] mask;
    mask = 3'((4'd1 << size) - 4'd1);
    return (off & mask) != 3'd0;
  endfunction

  // Byte enables for an access; lanes past byte 7 fall off the top
  function automatic logic [7:0] lane_strb(input logic [2:0] off, input logic [1:0] size);
    logic [15:0] wide;
    wide = ((16'd1 << (5'd1 << size)) - 16'd1) << off;
    return wide[7:0];
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/response bus between the access unit and memory.
// Latency: n/a (wires only).
// Backpressure: request held by master until bus_req_ready; responses are never stalled.
interface mem_access_unit_if;
  logic        bus_req_valid;
  logic        bus_req_ready;
  logic [63:0] bus_req_addr;
  logic        bus_req_we;
  logic [63:0] bus_req_wdata;
  logic [7:0]  bus_req_wstrb;
  logic        bus_resp_valid;
  logic [63:0] bus_resp_rdata;

  modport master (
    output bus_req_valid, bus_req_addr, bus_req_we, bus_req_wdata, bus_req_wstrb,
    input  bus_req_ready, bus_resp_valid, bus_resp_rdata
  );

  modport slave (
    input  bus_req_valid, bus_req_addr, bus_req_we, bus_req_wdata, bus_req_wstrb,
    output bus_req_ready, bus_resp_valid, bus_resp_rdata
  );
endinterface

// File: rtl/mem_access_unit_load_align.sv
// Load data aligner: shifts the addressed bytes down and sign/zero-extends to 64 bits.
// Latency: combinational.
// Backpressure: none; bytes beyond lane 7 read as zero before extension.
module load_align
  import mem_access_unit_pkg::*;
(
  input  logic [63:0] rdata_i,
  input  logic [2:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [63:0] result_o
);

  logic [63:0] sh;
  assign sh = rdata_i >> {off_i, 3'b000};

  // Mask to access size, then extend from the top bit of that size
  always_comb begin
    result_o = sh;
    case (size_i)
      MEM_B:   result_o = unsigned_i ? {56'b0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
      MEM_H:   result_o = unsigned_i ? {48'b0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      MEM_W:   result_o = unsigned_i ? {32'b0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      default: result_o = sh;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// RV64 memory-access stage: passes ALU results through, runs loads/stores on the data bus.
// Latency: 1 cycle non-memory; 4 edges for a memory op with no bus wait states.
// Backpressure: stall held while a request waits for ready or a response; MISALIGN_TRAP_EN traps misaligned ops.
module mem_access_unit
  import mem_access_unit_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid,
  input  logic [MEM_OP_BUS-1:0] ex_mem_op,
  input  logic [REG_BUS-1:0]    ex_alu_result,
  input  logic [REG_BUS-1:0]    ex_store_data,
  input  logic [4:0]            ex_rd,
  output logic                  stall,
  mem_access_unit_if.master     bus,
  output logic                  me_valid,
  output logic [4:0]            me_rd,
  output logic [REG_BUS-1:0]    me_alu_result,
  output logic                  me_misalign
);

  state_e        state_q, state_d;
  mem_req_t      req_q, req_d;
  logic [63:0]   load_q, load_d;
  logic          me_valid_q, me_valid_d;
  logic [4:0]    me_rd_q, me_rd_d;
  logic [63:0]   me_res_q, me_res_d;
  logic [63:0]   load_aligned;
  logic          new_mem;
  logic          trap;

  assign new_mem = ex_valid && (ex_mem_op != MEM_NONE);

`ifdef MISALIGN_TRAP_EN
  logic misalign_q;
  // A misaligned op is only taken where a new op could be accepted
  assign trap = new_mem && ((state_q == ST_IDLE) || (state_q == ST_DONE)) &&
                is_misaligned(ex_alu_result[2:0], ex_mem_op[1:0]);
  // One-cycle exception pulse for a trapped access
  always_ff @(posedge clk) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= trap;
  end
  assign me_misalign = misalign_q;
`else
  assign trap        = 1'b0;
  assign me_misalign = 1'b0;
`endif

  load_align u_load_align (
    .rdata_i    (bus.bus_resp_rdata),
    .off_i      (req_q.addr[2:0]),
    .size_i     (req_q.op[1:0]),
    .unsigned_i (req_q.op[2]),
    .result_o   (load_aligned)
  );

  // Next state, stall and writeback selection
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    load_d     = load_q;
    me_valid_d = 1'b0;
    me_rd_d    = 5'd0;
    me_res_d   = me_res_q;
    stall      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ex_valid && (ex_mem_op == MEM_NONE)) begin
          me_valid_d = 1'b1;
          me_rd_d    = ex_rd;
          me_res_d   = ex_alu_result;
        end else if (new_mem && !trap) begin
          req_d   = '{op: ex_mem_op, addr: ex_alu_result, data: ex_store_data, rd: ex_rd};
          state_d = ST_REQ;
          stall   = 1'b1;
        end
      end
      ST_REQ: begin
        stall = 1'b1;
        if (bus.bus_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        stall = 1'b1;
        if (bus.bus_resp_valid) begin
          load_d  = load_aligned;
          state_d = ST_DONE;
        end
      end
      default: begin
        // Stores complete with no register write; result reports the address
        me_valid_d = 1'b1;
        me_rd_d    = req_q.op[3] ? 5'd0 : req_q.rd;
        me_res_d   = req_q.op[3] ? req_q.addr : load_q;
        state_d    = ST_IDLE;
        if (new_mem && !trap) begin
          req_d   = '{op: ex_mem_op, addr: ex_alu_result, data: ex_store_data, rd: ex_rd};
          state_d = ST_REQ;
          stall   = 1'b1;
        end
      end
    endcase
  end

  // State and pipeline registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      req_q      <= '0;
      load_q     <= '0;
      me_valid_q <= 1'b0;
      me_rd_q    <= 5'd0;
      me_res_q   <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      load_q     <= load_d;
      me_valid_q <= me_valid_d;
      me_rd_q    <= me_rd_d;
      me_res_q   <= me_res_d;
    end
  end

  assign bus.bus_req_valid = (state_q == ST_REQ);
  assign bus.bus_req_addr  = {req_q.addr[63:3], 3'b000};
  assign bus.bus_req_we    = req_q.op[3];
  assign bus.bus_req_wstrb = lane_strb(req_q.addr[2:0], req_q.op[1:0]);
  assign bus.bus_req_wdata = req_q.data << {req_q.addr[2:0], 3'b000};

  assign me_valid      = me_valid_q;
  assign me_rd         = me_rd_q;
  assign me_alu_result = me_res_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases then random traffic against a byte-level model.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int MAXC   = 8000;
  localparam int NRAND  = 300;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [3:0]  ex_mem_op;
  logic [63:0] ex_alu_result;
  logic [63:0] ex_store_data;
  logic [4:0]  ex_rd;
  logic        stall;
  logic        me_valid;
  logic [4:0]  me_rd;
  logic [63:0] me_alu_result;
  logic        me_misalign;

  mem_access_unit_if bus ();

  mem_access_unit dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .ex_mem_op     (ex_mem_op),
    .ex_alu_result (ex_alu_result),
    .ex_store_data (ex_store_data),
    .ex_rd         (ex_rd),
    .stall         (stall),
    .bus           (bus),
    .me_valid      (me_valid),
    .me_rd         (me_rd),
    .me_alu_result (me_alu_result),
    .me_misalign   (me_misalign)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [63:0] addr;
    logic [63:0] data;
    logic [4:0]  rd;
    logic [63:0] rdata;
    int          rdy_wait;
    int          resp_wait;
    bit          rst_in_wait;
    bit          lit;
    logic [63:0] lit_val;
  } ins_t;

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Expected registered outputs, indexed by cycle
  bit          exp_v   [MAXC+4];
  bit          exp_m   [MAXC+4];
  logic [4:0]  exp_rd  [MAXC+4];
  logic [63:0] exp_res [MAXC+4];
  bit          exp_chk [MAXC+4];
  bit          exp_lit [MAXC+4];
  logic [63:0] exp_litv[MAXC+4];

  ins_t dirq[$];
  ins_t cur, pres;
  bit   req_pend, resp_pend, late_resp;
  int   rdy_cnt, resp_cnt;
  int   rand_left;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, req);
    end
  endtask

  // Model: access size in bytes is 1<<size; offset is the low three address bits
  function automatic bit m_mis(input logic [63:0] addr, input logic [1:0] size);
    int off = int'(addr[2:0]);
    return (off % (1 << size)) != 0;
  endfunction

  function automatic logic [7:0] m_strb(input logic [63:0] addr, input logic [1:0] size);
    int off = int'(addr[2:0]);
    int nb  = 1 << size;
    logic [7:0] s = '0;
    for (int i = 0; i < 8; i++) if (i >= off && i < off + nb) s[i] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] m_load(input logic [63:0] rdata, input logic [63:0] addr,
                                         input logic [1:0] size, input bit uns);
    int off = int'(addr[2:0]);
    int nb  = 1 << size;
    logic [63:0] v = '0;
    for (int i = 0; i < nb; i++)
      if (off + i < 8) v[8*i +: 8] = rdata[8*(off+i) +: 8];
    if (!uns && size != 2'd3 && v[8*nb-1])
      for (int b = 8*nb; b < 64; b++) v[b] = 1'b1;
    return v;
  endfunction

  function automatic ins_t mk(input logic [3:0] op, input logic [63:0] addr,
                              input logic [63:0] data, input logic [4:0] rd,
                              input logic [63:0] rdata);
    ins_t t;
    t.op = op; t.addr = addr; t.data = data; t.rd = rd; t.rdata = rdata;
    t.rdy_wait = 0; t.resp_wait = 0; t.rst_in_wait = 1'b0;
    t.lit = 1'b0; t.lit_val = '0;
    return t;
  endfunction

  function automatic ins_t rand_ins();
    ins_t t;
    logic [1:0] sz;
    t = mk(4'h0, {$urandom, $urandom}, {$urandom, $urandom}, 5'($urandom_range(1, 31)),
           {$urandom, $urandom});
    sz = 2'($urandom_range(0, 3));
    if ($urandom_range(0, 3) == 0) t.op = MEM_NONE;
    else if ($urandom_range(0, 1) == 1) t.op = {2'b10, sz};
    else t.op = {1'b0, 1'($urandom_range(0, 1)), sz};
    if (t.op != MEM_NONE && $urandom_range(0, 1) == 1)
      t.addr[2:0] = t.addr[2:0] & ~3'((4'd1 << sz) - 4'd1);
    t.rdy_wait  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
    t.resp_wait = $urandom_range(0, 3);
    return t;
  endfunction

  initial begin
    ins_t t;
    bit done_cyc, rp, sp, exp_stall, finished;
    int idle_after;

    rst = 1'b1; ex_valid = 1'b0; ex_mem_op = MEM_NONE; ex_alu_result = '0;
    ex_store_data = '0; ex_rd = '0;
    bus.bus_req_ready = 1'b0; bus.bus_resp_valid = 1'b0; bus.bus_resp_rdata = '0;
    req_pend = 0; resp_pend = 0; late_resp = 0; rdy_cnt = 0; resp_cnt = 0;
    rand_left = NRAND; idle_after = 0; finished = 0;

    // Directed cases
    t = mk(MEM_NONE, 64'h1234, 64'h0, 5'd5, 64'h0); t.lit = 1; t.lit_val = 64'h1234;
    dirq.push_back(t);
    t = mk(4'b0000, 64'h1003, 64'h0, 5'd6, 64'h0000_0000_8000_0000);
    t.lit = 1; t.lit_val = 64'hFFFF_FFFF_FFFF_FF80; dirq.push_back(t);
    t = mk(4'b1001, 64'h2002, 64'hABCD, 5'd3, 64'h0); dirq.push_back(t);
    t = mk(4'b0011, 64'h4000, 64'h0, 5'd7, 64'hDEAD_BEEF_0123_4567);
    t.rdy_wait = 3; t.resp_wait = 2; t.lit = 1; t.lit_val = 64'hDEAD_BEEF_0123_4567;
    dirq.push_back(t);
    t = mk(4'b0010, 64'h5000, 64'h0, 5'd8, 64'h0); t.rst_in_wait = 1; dirq.push_back(t);
    t = mk(4'b0010, 64'h3002, 64'h0, 5'd9, 64'h1122_3344_5566_7788);
    t.lit = 1; t.lit_val = 64'h3344_5566; dirq.push_back(t);
    t = mk(4'b0010, 64'h3006, 64'h0, 5'd10, 64'h1122_3344_5566_7788);
    t.lit = 1; t.lit_val = 64'h0000_1122; dirq.push_back(t);

    while (!finished) begin
      @(negedge clk);
      // Registered outputs against the model
      if (cyc >= 1) begin
        chk("me_valid", me_valid, exp_v[cyc]);
        chk("me_misalign", me_misalign, exp_m[cyc]);
        if (exp_v[cyc] && me_valid) begin
          chk("me_rd", me_rd, exp_rd[cyc]);
          if (exp_chk[cyc]) chk("me_alu_result", me_alu_result, exp_res[cyc]);
          if (exp_lit[cyc]) chk("me_alu_result_literal", me_alu_result, exp_litv[cyc]);
        end
        chk("bus_req_valid", bus.bus_req_valid, req_pend);
        if (req_pend && bus.bus_req_valid) begin
          chk("bus_req_addr", bus.bus_req_addr, {cur.addr[63:3], 3'b000});
          chk("bus_req_we", bus.bus_req_we, cur.op[3]);
          if (cur.op[3]) begin
            chk("bus_req_wstrb", bus.bus_req_wstrb, m_strb(cur.addr, cur.op[1:0]));
            chk("bus_req_wdata", bus.bus_req_wdata, cur.data << (8 * int'(cur.addr[2:0])));
            if (cur.addr == 64'h2002) begin
              chk("sh_wstrb_literal", bus.bus_req_wstrb, 64'h0C);
              chk("sh_wdata_literal", bus.bus_req_wdata, 64'h0000_0000_ABCD_0000);
              chk("sh_addr_literal", bus.bus_req_addr, 64'h2000);
            end
          end
        end
      end
      if (cyc == 2) chk("reset_me_alu_result", me_alu_result, 64'h0);

      // Drive inputs for this cycle
      rst = (cyc < 2);
      ex_valid = 1'b0;
      ex_mem_op = 4'($urandom);
      bus.bus_resp_valid = 1'b0;
      bus.bus_req_ready = 1'($urandom);
      if (!rst) begin
        if (late_resp) begin
          bus.bus_resp_valid = 1'b1;
          bus.bus_resp_rdata = {$urandom, $urandom};
          late_resp = 0;
        end else if (req_pend) begin
          if (rdy_cnt == 0) bus.bus_req_ready = 1'b1;
          else begin bus.bus_req_ready = 1'b0; rdy_cnt--; end
        end else if (resp_pend) begin
          if (resp_cnt == 0) begin
            if (cur.rst_in_wait) begin
              rst = 1'b1; late_resp = 1;
            end else begin
              bus.bus_resp_valid = 1'b1;
              bus.bus_resp_rdata = cur.rdata;
            end
          end else resp_cnt--;
        end else if ($urandom_range(0, 7) == 0) begin
          bus.bus_resp_valid = 1'b1;
          bus.bus_resp_rdata = {$urandom, $urandom};
        end
      end
      if (!rst && !req_pend && !resp_pend) begin
        done_cyc = exp_v[cyc+1];
        if (dirq.size() > 0) begin
          if (!done_cyc && $urandom_range(0, 1) == 1) begin
            pres = dirq.pop_front();
            ex_valid = 1'b1;
          end
        end else if (rand_left > 0 && $urandom_range(0, 3) != 0) begin
          pres = rand_ins();
          if (done_cyc) pres.addr[2:0] = 3'b000;
          if (!(done_cyc && pres.op == MEM_NONE)) begin
            ex_valid = 1'b1;
            rand_left--;
          end
        end
        if (ex_valid) begin
          ex_mem_op = pres.op; ex_alu_result = pres.addr;
          ex_store_data = pres.data; ex_rd = pres.rd;
        end
      end

      #1;
      exp_stall = req_pend || resp_pend ||
                  (ex_valid && ex_mem_op != MEM_NONE && !(TRAP_EN && m_mis(ex_alu_result, ex_mem_op[1:0])));
      if (cyc >= 1) chk("stall", stall, exp_stall);

      @(posedge clk);
      rp = req_pend; sp = resp_pend;
      if (rst) begin
        req_pend = 0; resp_pend = 0;
        exp_v[cyc+1] = 0; exp_m[cyc+1] = 0;
      end else begin
        if (sp && bus.bus_resp_valid) begin
          resp_pend = 0;
          exp_v[cyc+2] = 1;
          exp_rd[cyc+2]  = cur.op[3] ? 5'd0 : cur.rd;
          exp_chk[cyc+2] = !cur.op[3];
          exp_res[cyc+2] = m_load(bus.bus_resp_rdata, cur.addr, cur.op[1:0], cur.op[2]);
          exp_lit[cyc+2] = cur.lit && !cur.op[3];
          exp_litv[cyc+2] = cur.lit_val;
        end
        if (rp && bus.bus_req_ready) begin
          req_pend = 0; resp_pend = 1; resp_cnt = cur.resp_wait;
        end
        if (ex_valid && !rp && !sp) begin
          if (ex_mem_op == MEM_NONE) begin
            exp_v[cyc+1] = 1; exp_rd[cyc+1] = ex_rd; exp_res[cyc+1] = ex_alu_result;
            exp_chk[cyc+1] = 1; exp_lit[cyc+1] = pres.lit; exp_litv[cyc+1] = pres.lit_val;
          end else if (TRAP_EN && m_mis(ex_alu_result, ex_mem_op[1:0])) begin
            exp_m[cyc+1] = 1;
          end else begin
            cur = pres; req_pend = 1; rdy_cnt = cur.rdy_wait;
          end
        end
      end
      cyc++;

      if (dirq.size() == 0 && rand_left == 0 && !req_pend && !resp_pend && !late_resp)
        idle_after++;
      else
        idle_after = 0;
      if (idle_after > 4) finished = 1;
      if (cyc >= MAXC) begin
        checks++; errors++;
        $display("FAIL timeout cyc=%0d actual=running required=drained", cyc);
        finished = 1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
